// File: rtl/data_island_packet_serializer.sv
// HDMI data-island packet serializer: shadows one header plus four subpackets on
// accept and emits them over 32 pixel clocks, appending BCH parity on the fly.
module data_island_packet_serializer (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         start,
  input  logic [23:0]  header,
  input  logic [223:0] sub,
  output logic [8:0]   packet_data,
  output logic         packet_valid,
  output logic         packet_last,
  output logic         busy,
  output logic         start_dropped
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] hdr_q, hdr_d;
  logic [55:0] sub_q [4];
  logic [55:0] sub_d [4];
  logic [7:0]  par_q [5];
  logic [7:0]  par_d [5];
  logic        drop_q, drop_d;
  logic        accept;

  function automatic logic [7:0] bch_step(input logic [7:0] p, input logic d);
    logic fb;
    fb = p[0] ^ d;
    return {1'b0, p[7:1]} ^ (fb ? 8'h83 : 8'h00);
  endfunction

  assign accept = start && ((state_q == IDLE) || (cnt_q == 5'd31));

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      drop_q  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) sub_q[k] <= '0;
      for (int unsigned k = 0; k < 5; k++) par_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      drop_q  <= drop_d;
      for (int unsigned k = 0; k < 4; k++) sub_q[k] <= sub_d[k];
      for (int unsigned k = 0; k < 5; k++) par_q[k] <= par_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    drop_d  = start && (state_q == SEND) && (cnt_q != 5'd31);
    for (int unsigned k = 0; k < 4; k++) sub_d[k] = sub_q[k];
    for (int unsigned k = 0; k < 5; k++) par_d[k] = par_q[k];

    case (state_q)
      IDLE: if (start) state_d = SEND;
      SEND: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31 && !start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d = '0;
      hdr_d = header;
      for (int unsigned k = 0; k < 4; k++) begin
        sub_d[k] = sub[56*k +: 56];
      end
      for (int unsigned k = 0; k < 5; k++) par_d[k] = '0;
    end else if (state_q == SEND) begin
      // Parity freezes once the data bits are exhausted so the parity phase reads a stable register.
      if (cnt_q < 5'd24) par_d[0] = bch_step(par_q[0], hdr_q[cnt_q]);
      if (cnt_q < 5'd28) begin
        for (int unsigned k = 0; k < 4; k++) begin
          par_d[k+1] = bch_step(bch_step(par_q[k+1], sub_q[k][{cnt_q, 1'b0}]),
                                sub_q[k][{cnt_q, 1'b1}]);
        end
      end
    end
  end

  always_comb begin
    packet_data  = '0;
    packet_valid = 1'b0;
    packet_last  = 1'b0;
    if (state_q == SEND) begin
      packet_valid = 1'b1;
      packet_last  = (cnt_q == 5'd31);
      packet_data[0] = (cnt_q < 5'd24) ? hdr_q[cnt_q] : par_q[0][cnt_q[2:0]];
      for (int unsigned k = 0; k < 4; k++) begin
        if (cnt_q < 5'd28) begin
          packet_data[1+k] = sub_q[k][{cnt_q, 1'b0}];
          packet_data[5+k] = sub_q[k][{cnt_q, 1'b1}];
        end else begin
          packet_data[1+k] = par_q[k+1][{cnt_q[1:0], 1'b0}];
          packet_data[5+k] = par_q[k+1][{cnt_q[1:0], 1'b1}];
        end
      end
    end
  end

  assign busy          = packet_valid;
  assign start_dropped = drop_q;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Bench for data_island_packet_serializer: a codeword-level model checked every
// cycle, plus literal expectations for the directed packets.
module tb_data_island_packet_serializer;

  logic         clk_pixel = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [23:0]  header = '0;
  logic [223:0] sub = '0;
  logic [8:0]   packet_data;
  logic         packet_valid, packet_last, busy, start_dropped;

  data_island_packet_serializer dut (
    .clk_pixel(clk_pixel), .reset(reset), .start(start), .header(header), .sub(sub),
    .packet_data(packet_data), .packet_valid(packet_valid), .packet_last(packet_last),
    .busy(busy), .start_dropped(start_dropped)
  );

  always #5 clk_pixel = ~clk_pixel;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] p;
    logic fb;
    p = '0;
    for (int i = 0; i < n; i++) begin
      fb = p[0] ^ bits[i];
      p  = {1'b0, p[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return p;
  endfunction

  // Model: on accept, build the whole 32-word packet from the header and subpacket codewords.
  int         m_pos = -1;
  bit         m_drop = 1'b0;
  bit         m_acc;
  logic [8:0] m_words [32];
  logic [31:0] hc;
  logic [63:0] sc [4];

  always @(posedge clk_pixel) begin
    if (reset) begin
      m_pos  = -1;
      m_drop = 1'b0;
    end else begin
      m_acc  = start && (m_pos < 0 || m_pos == 31);
      m_drop = start && m_pos >= 0 && m_pos != 31;
      if (m_acc) begin
        hc = {bch({40'd0, header}, 24), header};
        for (int k = 0; k < 4; k++) sc[k] = {bch({8'd0, sub[56*k +: 56]}, 56), sub[56*k +: 56]};
        for (int c = 0; c < 32; c++) begin
          m_words[c][0] = hc[c];
          for (int k = 0; k < 4; k++) begin
            m_words[c][1+k] = sc[k][2*c];
            m_words[c][5+k] = sc[k][2*c+1];
          end
        end
        m_pos = 0;
      end else if (m_pos == 31) m_pos = -1;
      else if (m_pos >= 0) m_pos++;
    end
  end

  always @(negedge clk_pixel) begin
    if (chk_en) begin
      if (m_pos >= 0)
        check("cycle", {19'd0, packet_data, packet_valid, packet_last, busy, start_dropped},
              {19'd0, m_words[m_pos], 1'b1, (m_pos == 31), 1'b1, m_drop});
      else
        check("cycle", {19'd0, packet_data, packet_valid, packet_last, busy, start_dropped},
              {19'd0, 9'd0, 1'b0, 1'b0, 1'b0, m_drop});
    end
  end

  logic [8:0] obs [32];
  int         nvalid, lastpos;

  task automatic send(input logic [23:0] h, input logic [223:0] s, input bit scramble);
    header = h;
    sub    = s;
    start  = 1'b1;
    @(negedge clk_pixel);
    start = 1'b0;
    nvalid = 0;
    lastpos = -1;
    for (int c = 0; c < 32; c++) begin
      obs[c] = packet_data;
      if (packet_valid) nvalid++;
      if (packet_last) lastpos = c;
      if (scramble) begin
        header = 24'($urandom);
        sub = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1'b0;
      end
      @(negedge clk_pixel);
    end
  endtask

  logic [7:0] bits8;
  logic [8:0] orall;

  initial begin
    repeat (2) @(negedge clk_pixel);
    chk_en = 1'b1;
    check("reset_outputs", {19'd0, packet_data, packet_valid, packet_last, busy, start_dropped}, 32'd0);
    reset = 1'b0;
    @(negedge clk_pixel);

    // 1: all-zero packet
    send(24'd0, 224'd0, 1'b0);
    orall = '0;
    for (int c = 0; c < 32; c++) orall |= obs[c];
    check("t1_valid_cycles", nvalid, 32);
    check("t1_last_pos", lastpos, 31);
    check("t1_data_zero", {23'd0, orall}, 0);
    check("t1_idle_after", packet_valid, 0);

    // 2: header MSB only -> parity 0x83
    send(24'h800000, 224'd0, 1'b0);
    check("t2_c23", obs[23][0], 1);
    for (int i = 0; i < 8; i++) bits8[i] = obs[24+i][0];
    check("t2_hdr_parity", bits8, 8'h83);

    // 3: subpacket 0 MSB only
    send(24'd0, {168'd0, 56'h80000000000000}, 1'b0);
    check("t3_c27_odd", obs[27][5], 1);
    for (int i = 0; i < 4; i++) begin
      bits8[2*i]   = obs[28+i][1];
      bits8[2*i+1] = obs[28+i][5];
    end
    check("t3_sub_parity", bits8, 8'h83);

    // 4: start held for 70 cycles
    header = 24'h0a0b0c;
    sub = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk_pixel);
      if (i == 2)  check("t4_drop_c1", start_dropped, 1);
      if (i == 32) check("t4_last1", packet_last, 1);
      if (i == 33) check("t4_no_drop_at_accept", start_dropped, 0);
      if (i == 64) check("t4_last2", packet_last, 1);
      if (i == 65) check("t4_pkt3_valid", {packet_valid, packet_last}, 2'b10);
    end
    start = 1'b0;
    for (int i = 0; i < 40 && packet_valid; i++) @(negedge clk_pixel);
    check("t4_idle", packet_valid, 0);

    // 5: inputs scrambled after accept; SPD header
    send(24'h190183, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
    check("t5_valid_cycles", nvalid, 32);
    header = '0;
    sub = '0;
    repeat (2) @(negedge clk_pixel);

    // 6: reset mid-packet, then a clean packet
    header = 24'h5a5a5a;
    sub = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk_pixel);
    start = 1'b0;
    repeat (10) @(negedge clk_pixel);
    check("t6_pre_reset_valid", packet_valid, 1);
    reset = 1'b1;
    @(negedge clk_pixel);
    check("t6_reset_outputs", {19'd0, packet_data, packet_valid, packet_last, busy, start_dropped}, 32'd0);
    reset = 1'b0;
    @(negedge clk_pixel);
    send(24'hc3a512, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
    check("t6_valid_cycles", nvalid, 32);
    check("t6_last_pos", lastpos, 31);

    repeat (3) @(negedge clk_pixel);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
